// File: rtl/tt_pwm_bank.sv
// tt_pwm_bank: multi-channel, double-buffered PWM bank on the TinyTapeout user-module pin set.
// Define TT_PWM_CENTER_EN to build center-aligned counting (CTRL[4]); otherwise only edge-aligned exists.
module tt_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [2:0]       ADDR_TOP  = 3'd6;
    localparam logic [2:0]       ADDR_CTRL = 3'd7;
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    logic [1:0]       strb_sync_q;
    logic             strb_prev_q;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] duty_q   [CHANNELS];
    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] top_q;
    logic [5:0]       ctrl_q;

    logic [3:0]       presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             run, active, tick, wrap;
    logic [CHANNELS-1:0] out_q, out_d;
    logic             wrap_q;
`ifdef TT_PWM_CENTER_EN
    logic             dir_q, dir_d;
`endif

    // The strobe is asynchronous: two flops for metastability, a third to find its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_sync_q <= '0;
            strb_prev_q <= 1'b0;
        end else begin
            strb_sync_q <= {strb_sync_q[0], ui_in[7]};
            strb_prev_q <= strb_sync_q[1];
        end
    end

    assign wr_en   = strb_sync_q[1] & ~strb_prev_q;
    assign wr_addr = ui_in[6:4];
    assign wr_data = uio_in[WIDTH-1:0];

    // NOTE: the duty/shadow arrays are plain flops, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) duty_q[i] <= '0;
            top_q  <= CNT_MAX;
            ctrl_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == 3'(i)) duty_q[i] <= wr_data;
            end
            if (wr_addr == ADDR_TOP)  top_q  <= wr_data;
            if (wr_addr == ADDR_CTRL) ctrl_q <= uio_in[5:0];
        end
    end

    assign run     = ctrl_q[5];
    assign active  = run & ena;
    assign tick    = active & (presc_q == ctrl_q[3:0]);
    assign presc_d = (!active || tick) ? 4'd0 : presc_q + 4'd1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
`ifdef TT_PWM_CENTER_EN
        dir_d = dir_q;
`endif
        if (!run) begin
            cnt_d = '0;
`ifdef TT_PWM_CENTER_EN
            dir_d = 1'b0;
`endif
        end else if (tick) begin
`ifdef TT_PWM_CENTER_EN
            if (ctrl_q[4]) begin
                // Up to the peak, back down to 1; the valley (or a TOP of 0/1) is the wrap.
                if (!dir_q) begin
                    if (cnt_q == top_q || cnt_q == CNT_MAX) begin
                        if (cnt_q <= CNT_ONE) begin
                            cnt_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                            dir_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (cnt_q <= CNT_ONE) begin
                    cnt_d = '0;
                    dir_d = 1'b0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else begin
                dir_d = 1'b0;
                if (cnt_q == top_q || cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`else
            // A TOP lowered below the count lets it run on to all-ones and wrap there.
            if (cnt_q == top_q || cnt_q == CNT_MAX) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
`endif
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < CHANNELS; i++) out_d[i] = active & (cnt_q < shadow_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
`ifdef TT_PWM_CENTER_EN
            dir_q   <= 1'b0;
`endif
            for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
`ifdef TT_PWM_CENTER_EN
            dir_q   <= dir_d;
`endif
            // Shadows reload only at the wrap, so a period never changes width once started.
            if (wrap) begin
                for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= duty_q[i];
            end
            out_q  <= out_d;
            wrap_q <= wrap;
        end
    end

    always_comb begin
        uo_out                 = '0;
        uo_out[CHANNELS-1:0]   = out_q;
        uo_out[7]              = wrap_q;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = ^{ui_in[3:0], uio_in, ctrl_q[4]};

endmodule

// File: tb/tb_tt_pwm_bank.sv
// tb_tt_pwm_bank: directed and randomized bench for tt_pwm_bank, compared every cycle
// against a period-position model of the PWM bank.
module tb_tt_pwm_bank;
    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
`ifdef TT_PWM_CENTER_EN
    localparam bit CENTER_BUILT = 1'b1;
`else
    localparam bit CENTER_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    tt_pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the position within the current period and derives the counter level from it.
    int         m_duty   [CH];
    int         m_shadow [CH];
    int         m_top, m_ctrl, m_pos, m_pcnt, m_run_len;
    logic [7:0] m_uo;

    function automatic bit ctr_mode();
        return CENTER_BUILT && (m_ctrl[4] == 1'b1);
    endfunction

    function automatic int period_of(input int top, input bit c);
        if (!c) return top + 1;
        return (top == 0) ? 1 : 2 * top;
    endfunction

    function automatic int level_of(input int pos, input int top, input bit c);
        return (c && pos > top) ? 2 * top - pos : pos;
    endfunction

    function automatic bit tick_now();
        return m_ctrl[5] && ena && (m_pcnt == (m_ctrl & 15));
    endfunction

    function automatic bit wrap_now();
        bit c;
        c = ctr_mode();
        return tick_now() && (m_pos == period_of(m_top, c) - 1 || (!c && m_pos == MAXV));
    endfunction

    function automatic logic [7:0] expected_uo();
        logic [7:0] u;
        int lvl;
        u   = '0;
        lvl = level_of(m_pos, m_top, ctr_mode());
        for (int i = 0; i < CH; i++) u[i] = (lvl < m_shadow[i]) && m_ctrl[5] && ena;
        u[7] = wrap_now();
        return u;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_duty[i]   <= 0;
                m_shadow[i] <= 0;
            end
            m_top     <= MAXV;
            m_ctrl    <= 0;
            m_pos     <= 0;
            m_pcnt    <= 0;
            m_run_len <= 0;
            m_uo      <= '0;
        end else begin
            m_uo <= expected_uo();
            if (!m_ctrl[5]) begin
                m_pos  <= 0;
                m_pcnt <= 0;
            end else if (!ena) begin
                m_pcnt <= 0;
            end else begin
                m_pcnt <= (m_pcnt == (m_ctrl & 15)) ? 0 : (m_pcnt + 1) % 16;
                if (tick_now()) begin
                    if (wrap_now()) begin
                        m_pos <= 0;
                        for (int i = 0; i < CH; i++) m_shadow[i] <= m_duty[i];
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            end
            // A write lands on the third consecutive edge that samples the strobe high.
            m_run_len <= ui_in[7] ? ((m_run_len < 3) ? m_run_len + 1 : 3) : 0;
            if (ui_in[7] && m_run_len == 2) begin
                if (int'(ui_in[6:4]) < CH) m_duty[int'(ui_in[6:4])] <= int'(uio_in) & MAXV;
                else if (ui_in[6:4] == 3'd6) m_top <= int'(uio_in) & MAXV;
                else if (ui_in[6:4] == 3'd7) m_ctrl <= int'(uio_in) & 'h3F;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("uo_out", {24'h0, uo_out}, {24'h0, m_uo});
            check("uio_out_oe", {16'h0, uio_oe, uio_out}, 32'h0);
        end
    end

    // ---------------- stimulus helpers (all entered on a falling edge) ----------------
    task automatic wr(input int addr, input int data);
        ui_in  = {1'b1, 3'(addr), 4'b0000};
        uio_in = 8'(data);
        repeat (4) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_wrap();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (uo_out[7]) return;
        end
        check("wrap_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap_to_wrap(output int g);
        g = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            g++;
            if (uo_out[7]) return;
        end
    endtask

    task automatic sample_window(input int n, output int c0, output int c1, output int c2,
                                 output int c7, output int any);
        c0 = 0; c1 = 0; c2 = 0; c7 = 0; any = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (uo_out[0]) c0++;
            if (uo_out[1]) c1++;
            if (uo_out[2]) c2++;
            if (uo_out[7]) c7++;
            if (uo_out != 8'h00) any++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c7, any, g, per;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        check("reset_uo_out", {24'h0, uo_out}, 32'h0);
        check("reset_uio_oe", {24'h0, uio_oe}, 32'h0);
        check("reset_uio_out", {24'h0, uio_out}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        sample_window(20, c0, c1, c2, c7, any);
        check("idle_after_reset", any, 0);

        // Basic PWM and duty extremes: TOP=9.
        wr(0, 3); wr(1, 0); wr(2, 10); wr(6, 9); wr(7, 'h20);
        wait_wrap();
        sample_window(10, c0, c1, c2, c7, any);
        check("basic_duty3_high", c0, 3);
        check("basic_duty0_high", c1, 0);
        check("basic_duty10_high", c2, 10);
        check("basic_wrap_count", c7, 1);
        gap_to_wrap(g);
        check("basic_period", g, 10);

        // Double buffer: DUTY[0] 3->7 mid-period.
        wait_wrap();
        fork
            begin
                repeat (2) @(negedge clk);
                wr(0, 7);
            end
            sample_window(10, c0, c1, c2, c7, any);
        join
        check("dbuf_current_period", c0, 3);
        sample_window(10, c0, c1, c2, c7, any);
        check("dbuf_next_period", c0, 7);

        // Prescaler 3 and an ena freeze right after a wrap.
        wr(0, 3); wr(7, 'h00); wr(7, 'h23);
        wait_wrap();
        sample_window(40, c0, c1, c2, c7, any);
        check("presc_high", c0, 12);
        check("presc_wrap_count", c7, 1);
        ena = 1'b0;
        sample_window(7, c0, c1, c2, c7, any);
        check("ena_low_outputs", any, 0);
        ena = 1'b1;
        gap_to_wrap(g);
        check("ena_resume_gap", g, 40);

        // TOP=0: one-tick period.
        wr(7, 'h00); wr(0, 1); wr(6, 0); wr(7, 'h20);
        repeat (3) @(negedge clk);
        sample_window(8, c0, c1, c2, c7, any);
        check("top0_duty1_high", c0, 8);
        check("top0_duty0_high", c1, 0);
        check("top0_wrap_every_clk", c7, 8);

        // Center mode request: TOP=4, DUTY[0]=2, CTRL=0x30.
        wr(7, 'h00); wr(6, 4); wr(0, 2); wr(7, 'h30);
        wait_wrap();
        wait_wrap();
        per = CENTER_BUILT ? 8 : 5;
        sample_window(per, c0, c1, c2, c7, any);
        check("center_high", c0, CENTER_BUILT ? 3 : 2);
        check("center_wrap_count", c7, 1);
        gap_to_wrap(g);
        check("center_period", g, per);

        // Randomized phases: reconfigure with RUN low, then run with random duty writes and ena drops.
        for (int ph = 0; ph < 12; ph++) begin
            int top, presc, ctr;
            top   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
            presc = $urandom_range(0, 3);
            ctr   = $urandom_range(0, 1);
            wr(7, presc);
            wr(6, top);
            for (int c = 0; c < CH; c++) wr(c, $urandom_range(0, top + 2));
            wr(7, 'h20 | (ctr << 4) | presc);
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ena = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    ena = 1'b1;
                end
                wr($urandom_range(0, 5), $urandom_range(0, top + 2));
                repeat ($urandom_range(0, 8)) @(negedge clk);
            end
        end

        // Asynchronous reset mid-operation.
        wr(7, 'h00); wr(6, 0); wr(0, 1); wr(7, 'h20);
        repeat (4) @(negedge clk);
        check("pre_reset_active", {24'h0, uo_out & 8'h81}, 32'h81);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", {24'h0, uo_out}, 32'h0);
        check("async_reset_uio_oe", {24'h0, uio_oe}, 32'h0);
        check("async_reset_uio_out", {24'h0, uio_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sample_window(20, c0, c1, c2, c7, any);
        check("run_cleared_after_reset", any, 0);
        wr(6, 3); wr(0, 2); wr(7, 'h22);
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_pwm_bank.md
# tt_pwm_bank

Parametrised multi-channel PWM generator wrapped in the standard TinyTapeout user-module port set (clk, rst_n, ena, ui_in, uo_out, uio_in, uio_out, uio_oe). It is the successor to the team's fixed single-function tile. Channel count, counter width, period and prescaler are all configurable. Channels are programmed through a strobed byte-write port on the dedicated pins and produce glitch-free, double-buffered PWM waveforms on uo_out.

## Interface
- CHANNELS, 4: number of PWM channels, legal range 1..6.
- WIDTH, 8: counter, duty and period width, legal range 4..8.
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design selected; when low, the counters freeze and uo_out is forced to 0.
- ui_in  in  8  [7] write strobe (asynchronous to clk); [6:4] register address; [3:0] unused.
- uio_in  in  8  write data; bits [WIDTH-1:0] are used.
- uo_out  out  8  [CHANNELS-1:0] PWM outputs; [7] period-wrap pulse; the remaining bits are 0.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

## Operation
- Register map:
  - Addresses 0..CHANNELS-1: DUTY[i].
  - Address 6: TOP (period minus 1).
  - Address 7: CTRL, with [3:0] PRESC, [4] CENTER, [5] RUN.
  - All other addresses: writes are ignored.
- Reset values:
  - DUTY = 0, shadow duty = 0.
  - TOP = 2^WIDTH-1.
  - CTRL = 0.
  - Counter = 0, prescaler = 0, direction = up.
  - uo_out = 0.
- Write path:
  - ui_in[7] passes through a 2-flop synchronizer plus an edge-detect flop.
  - The rising edge commits ui_in[6:4] and uio_in to the addressed register.
  - Address and data must be stable from strobe rise until the commit edge.
  - A strobe held high produces exactly one write.
- Prescaler:
  - The prescaler counts 0..PRESC.
  - A tick is issued when the prescaler equals PRESC, i.e. one tick every PRESC+1 clocks.
  - The prescaler is held at 0 while RUN=0 or ena=0.
- Edge-aligned mode (CENTER=0):
  - The counter counts 0..TOP on ticks, then wraps to 0.
  - Shadow duty registers load from DUTY[i] on the wrap tick (TOP→0).
- Outputs:
  - uo_out[i] is registered as (counter < shadow[i]) & RUN & ena.
  - shadow ≥ TOP+1 gives constant high; shadow = 0 gives constant low.
  - TOP = 0 gives a 1-tick period.
- Wrap pulse: uo_out[7] is high for exactly one clk on each wrap tick.
- RUN cleared: the counter, prescaler and direction reset to 0/up on the next edge, and outputs go to 0.

## Timing
- Write latency: the register updates on the 3rd rising clk edge that samples ui_in[7] high.
- Duty update: takes effect at the first wrap after the commit. There are never runt or extended pulses mid-period.
- Simultaneous write to DUTY[i] and wrap on the same edge: the shadow takes the old DUTY value and the new value applies from the next wrap.
- TOP written below the current counter value: the counter continues up to 2^WIDTH-1 and wraps naturally. No early wrap is required.
- Output latency: uo_out[i] lags the counter by one clk.
- Asynchronous reset mid-operation: all outputs drop to 0 immediately. The first tick after rst_n rises and RUN is set occurs PRESC+1 clocks later.

## Configuration
- Macro TT_PWM_CENTER_EN.
- Defined: CTRL[4]=1 selects center-aligned mode.
  - The counter counts up 0..TOP, then down TOP-1..1, repeating.
  - Period is 2·TOP ticks, or 1 tick when TOP=0.
  - The wrap pulse and shadow load occur at the valley (1→0 in the down direction, or at TOP=0).
- Undefined: CTRL[4] is stored but ignored, and the direction logic is not built. Only edge-aligned mode exists.

## Test plan
- Reset: assert rst_n=0 mid-stream -> uo_out=0x00, uio_oe=0x00, uio_out=0x00 immediately; a CTRL readback via behaviour shows RUN=0 (no toggling).
- Basic PWM: TOP=9, DUTY[0]=3, CTRL=0x20, ena=1 -> uo_out[0] high 3 of every 10 clks; uo_out[7] one-clk pulse every 10 clks.
- Double buffer: change DUTY[0] 3→7 at counter=5 -> the current period keeps width 3, and the next period is high for 7.
- Extremes: DUTY[1]=0 -> uo_out[1] constantly 0; DUTY[2]=10 with TOP=9 -> uo_out[2] constantly 1; TOP=0, DUTY=1 -> constant 1, wrap pulse every clk.
- Prescaler/ena: PRESC=3, TOP=9 -> period 40 clks; drop ena for 7 clks -> outputs 0 and the period resumes where it froze.
- Center mode (TT_PWM_CENTER_EN): TOP=4, DUTY[0]=2, CTRL=0x30 -> 8-clk period, uo_out[0] high 3 clks per period, wrap pulse at the valley; with the macro undefined, the same stimulus gives a 5-clk edge-aligned period.
